// File: rtl/cache_pkg.sv
// Shared types for the write-back buffer: default widths, the buffered entry
// record and the drain FSM state encoding.
package cache_pkg;
    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 32;

    typedef struct packed {
        logic                     valid;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]    data;
    } wb_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } drain_state_t;
endpackage

// File: rtl/write_back_buffer_if.sv
// Eviction, memory-write and lookup signals of the write-back buffer; master is
// the cache/memory side, slave is the buffer.
interface write_back_buffer_if #(
    parameter int DATA_WIDTH    = cache_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = cache_pkg::ADDRESS_WIDTH
);
    logic                     wb_valid;
    logic [ADDRESS_WIDTH-1:0] wb_address;
    logic [DATA_WIDTH-1:0]    wb_data;
    logic                     wb_full;
    logic                     mem_write_enable;
    logic [ADDRESS_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic                     mem_ack;
    logic [ADDRESS_WIDTH-1:0] lookup_address;
    logic                     lookup_hit;
    logic [DATA_WIDTH-1:0]    lookup_data;

    modport master (
        output wb_valid, wb_address, wb_data, mem_ack, lookup_address,
        input  wb_full, mem_write_enable, mem_address, mem_write_data, lookup_hit, lookup_data
    );

    modport slave (
        input  wb_valid, wb_address, wb_data, mem_ack, lookup_address,
        output wb_full, mem_write_enable, mem_address, mem_write_data, lookup_hit, lookup_data
    );
endinterface

// File: rtl/wb_lookup_match.sv
// Compares one address (word granularity) against every buffer entry and
// reports the youngest match, scanning in age order starting at the head.
module wb_lookup_match #(
    parameter int  ADDRESS_WIDTH = 32,
    parameter int  DEPTH         = 4,
    localparam int PTR_W         = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]                    valid,
    input  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] addresses,
    input  logic [PTR_W-1:0]                    head,
    input  logic [ADDRESS_WIDTH-1:0]            query,
    output logic                                hit,
    output logic [PTR_W-1:0]                    index
);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = ~ADDRESS_WIDTH'(3);

    logic [PTR_W-1:0] idx;

    // Later iterations are younger, so the last match found wins.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (valid[idx] && (((addresses[idx] ^ query) & WORD_MASK) == '0)) begin
                hit   = 1'b1;
                index = idx;
            end
        end
    end
endmodule

// File: rtl/write_back_buffer.sv
// Write-back buffer: queues dirty evictions until memory accepts them, merges
// repeat evictions of the same word and serves buffered data to cache misses.
//
// state | meaning
// IDLE  | memory port quiet; leaves as soon as any entry is buffered
// WRITE | head entry in flight on the memory port until mem_ack pops it
module write_back_buffer #(
    parameter int DATA_WIDTH    = cache_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = cache_pkg::ADDRESS_WIDTH,
    parameter int DEPTH         = 4
) (
    input logic                clk,
    input logic                rst,
    write_back_buffer_if.slave bus
);
    import cache_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t [DEPTH-1:0]               entries;
    logic [PTR_W-1:0]                    head;
    logic [PTR_W-1:0]                    tail;
    logic [PTR_W:0]                      count;
    logic [PTR_W:0]                      count_next;
    drain_state_t                        state;
    drain_state_t                        state_next;

    logic [DEPTH-1:0]                    valid_all;
    logic [DEPTH-1:0]                    valid_free;
    logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] entry_address;
    logic                                coal_hit;
    logic [PTR_W-1:0]                    coal_idx;
    logic                                look_hit;
    logic [PTR_W-1:0]                    look_idx;
    logic                                alloc;
    logic                                pop;

    // The in-flight head is excluded from merging so the memory port stays stable.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_all[i]     = entries[i].valid;
            entry_address[i] = entries[i].address;
        end
        valid_free = valid_all;
        if (state == WRITE) begin
            valid_free[head] = 1'b0;
        end
    end

    wb_lookup_match #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DEPTH(DEPTH)) u_coalesce (
        .valid     (valid_free),
        .addresses (entry_address),
        .head      (head),
        .query     (bus.wb_address),
        .hit       (coal_hit),
        .index     (coal_idx)
    );

    wb_lookup_match #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .DEPTH(DEPTH)) u_lookup (
        .valid     (valid_all),
        .addresses (entry_address),
        .head      (head),
        .query     (bus.lookup_address),
        .hit       (look_hit),
        .index     (look_idx)
    );

    assign bus.wb_full = (count == (PTR_W+1)'(DEPTH));
    assign alloc       = bus.wb_valid && !coal_hit && !bus.wb_full;
    assign pop         = (state == WRITE) && bus.mem_ack;
    assign count_next  = count + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = WRITE;
            WRITE:   if (pop && (count_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            state <= state_next;
            count <= count_next;
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            if (bus.wb_valid && coal_hit) begin
                entries[coal_idx].data <= bus.wb_data;
            end else if (alloc) begin
                entries[tail].valid   <= 1'b1;
                entries[tail].address <= bus.wb_address;
                entries[tail].data    <= bus.wb_data;
                tail                  <= tail + PTR_W'(1);
            end
        end
    end

    assign bus.mem_write_enable = (state == WRITE);
    assign bus.mem_address      = (state == WRITE) ? entries[head].address : '0;
    assign bus.mem_write_data   = (state == WRITE) ? entries[head].data : '0;
    assign bus.lookup_hit       = look_hit;
    assign bus.lookup_data      = look_hit ? entries[look_idx].data : '0;
endmodule

// File: tb/tb_write_back_buffer.sv
// Directed scenarios followed by random traffic, checked against a queue-based
// model of the buffer's contents and memory write order.
module tb_write_back_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    write_back_buffer_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

    write_back_buffer #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];          // model: oldest entry first
    ent_t dut_writes[$];  // writes the DUT actually had accepted by memory
    logic busy = 1'b0;    // model: head is on the memory port
    int   checks = 0;
    int   errors = 0;
    int   refused = 0;
    int   nw;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int coalesce_slot(input logic [31:0] a);
        int s;
        s = -1;
        for (int j = (busy ? 1 : 0); j < mq.size(); j++) begin
            if (mq[j].addr[31:2] == a[31:2]) s = j;
        end
        return s;
    endfunction

    task automatic compare_outputs(input logic [31:0] la, input logic ack);
        logic        hit;
        logic [31:0] ld;
        logic [31:0] ea;
        logic [31:0] ed;
        hit = 1'b0;
        ld  = 32'h0;
        for (int j = mq.size() - 1; j >= 0; j--) begin
            if (!hit && (mq[j].addr[31:2] == la[31:2])) begin
                hit = 1'b1;
                ld  = mq[j].data;
            end
        end
        ea = 32'h0;
        ed = 32'h0;
        if (busy) begin
            ea = mq[0].addr;
            ed = mq[0].data;
        end
        chk("wb_full", 64'(bus.wb_full), 64'(mq.size() == DEPTH));
        chk("mem_write_enable", 64'(bus.mem_write_enable), 64'(busy));
        chk("mem_address", 64'(bus.mem_address), 64'(ea));
        chk("mem_write_data", 64'(bus.mem_write_data), 64'(ed));
        chk("lookup_hit", 64'(bus.lookup_hit), 64'(hit));
        chk("lookup_data", 64'(bus.lookup_data), 64'(ld));
        if (bus.mem_write_enable && ack) begin
            dut_writes.push_back('{bus.mem_address, bus.mem_write_data});
        end
    endtask

    task automatic model_update(input logic v, input logic [31:0] a, input logic [31:0] d, input logic ack);
        int   slot;
        int   size_before;
        logic pop;
        size_before = mq.size();
        pop         = busy && ack;
        if (v) begin
            slot = coalesce_slot(a);
            if (slot >= 0) begin
                mq[slot].data = d;
            end else if (size_before < DEPTH) begin
                mq.push_back('{a, d});
            end else begin
                refused++;
                $display("flagged: push to full buffer refused, addr=%h", a);
            end
        end
        if (pop) mq.delete(0);
        busy = busy ? (mq.size() != 0) : (size_before != 0);
    endtask

    // Drive one cycle's inputs at the negedge and check outputs; caller then
    // may add checks before advancing to the posedge.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic ack, input logic [31:0] la);
        @(negedge clk);
        rst                = 1'b0;
        bus.wb_valid       = v;
        bus.wb_address     = a;
        bus.wb_data        = d;
        bus.mem_ack        = ack;
        bus.lookup_address = la;
        #1;
        compare_outputs(la, ack);
        model_update(v, a, d, ack);
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic ack, input logic [31:0] la);
        drive(v, a, d, ack, la);
        @(posedge clk);
    endtask

    task automatic do_reset(input logic ack);
        @(negedge clk);
        rst          = 1'b1;
        bus.wb_valid = 1'b0;
        bus.mem_ack  = ack;
        @(posedge clk);
        mq.delete();
        busy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_valid       = 1'b0;
        bus.wb_address     = 32'h0;
        bus.wb_data        = 32'h0;
        bus.mem_ack        = 1'b0;
        bus.lookup_address = 32'h0;
        do_reset(1'b0);
        do_reset(1'b0);

        // Reset state, then single eviction with ack two cycles after the push
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h40);
        chk("rst_mem_address", 64'(bus.mem_address), 64'h0);
        chk("rst_lookup_hit", 64'(bus.lookup_hit), 64'h0);
        @(posedge clk);
        step(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h40);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h40);
        chk("s037_we_not_yet", 64'(bus.mem_write_enable), 64'h0);
        chk("s037_lookup", 64'(bus.lookup_data), 64'hDEAD_BEEF);
        @(posedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
        chk("s037_we", 64'(bus.mem_write_enable), 64'h1);
        chk("s037_addr", 64'(bus.mem_address), 64'h40);
        @(posedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h40);
        chk("s037_idle", 64'(bus.mem_write_enable), 64'h0);
        chk("s037_empty", 64'(bus.lookup_hit), 64'h0);
        @(posedge clk);
        chk("s037_nwrites", 64'(dut_writes.size()), 64'h1);
        chk("s037_write", {dut_writes[0].addr, dut_writes[0].data}, {32'h40, 32'hDEAD_BEEF});

        // Fill with four distinct addresses (0x100 youngest), then merge into 0x100
        nw = dut_writes.size();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h10C - 32'(i) * 4, 32'hA0 + 32'(i), 1'b0, 32'h100);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h100);
        chk("s038_full", 64'(bus.wb_full), 64'h1);
        @(posedge clk);
        step(1'b1, 32'h100, 32'hC0FF_EE00, 1'b0, 32'h100);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h100);
        chk("s039_still_full", 64'(bus.wb_full), 64'h1);
        chk("s039_lookup", 64'(bus.lookup_data), 64'hC0FF_EE00);
        @(posedge clk);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("s039_first", {dut_writes[nw].addr, dut_writes[nw].data}, {32'h10C, 32'hA0});
        chk("s039_merged", {dut_writes[nw+3].addr, dut_writes[nw+3].data}, {32'h100, 32'hC0FF_EE00});

        // Push matching the in-flight head must allocate a newer copy
        nw = dut_writes.size();
        step(1'b1, 32'h200, 32'hAAAA_AAAA, 1'b0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 32'h200, 32'h1111_1111, 1'b0, 32'h200);
        chk("s040_inflight", 64'(bus.mem_address), 64'h200);
        chk("s040_no_same_cycle", 64'(bus.lookup_data), 64'hAAAA_AAAA);
        @(posedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h200);
        chk("s040_lookup_newer", 64'(bus.lookup_data), 64'h1111_1111);
        chk("s040_held", 64'(bus.mem_write_data), 64'hAAAA_AAAA);
        @(posedge clk);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h200);
        chk("s040_w0", {dut_writes[nw].addr, dut_writes[nw].data}, {32'h200, 32'hAAAA_AAAA});
        chk("s040_w1", {dut_writes[nw+1].addr, dut_writes[nw+1].data}, {32'h200, 32'h1111_1111});

        // Full buffer: pop and refused push in the same cycle
        for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(i) * 4, 32'h30 + 32'(i), 1'b0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("s041_full", 64'(bus.wb_full), 64'h1);
        @(posedge clk);
        step(1'b1, 32'h400, 32'h4444_4444, 1'b1, 32'h400);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h400);
        chk("s041_not_full", 64'(bus.wb_full), 64'h0);
        chk("s041_refused", 64'(bus.lookup_hit), 64'h0);
        chk("s041_new_head", 64'(bus.mem_address), 64'h304);
        @(posedge clk);

        // Reset while writing with mem_ack high
        nw = dut_writes.size();
        do_reset(1'b1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h308);
        chk("s042_we", 64'(bus.mem_write_enable), 64'h0);
        chk("s042_lookup", 64'(bus.lookup_hit), 64'h0);
        chk("s042_full", 64'(bus.wb_full), 64'h0);
        @(posedge clk);

        // Eight back-to-back alloc/pop pairs wrap the pointers
        nw = dut_writes.size();
        step(1'b1, 32'h500, 32'h5000_0000, 1'b0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 32'h500 + 32'(i) * 4, 32'h5000_0000 + 32'(i), 1'b1, 32'h500 + 32'(i) * 4);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("s043_order", {dut_writes[nw+i].addr, dut_writes[nw+i].data},
                {32'h500 + 32'(i) * 4, 32'h5000_0000 + 32'(i)});
        end

        // Random traffic; the upstream never pushes a non-mergeable word when full
        for (int c = 0; c < 400; c++) begin
            logic        v;
            logic        ack;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] la;
            a   = 32'h600 + 32'($urandom_range(0, 5)) * 4;
            d   = $urandom;
            la  = 32'h600 + 32'($urandom_range(0, 6)) * 4 + 32'($urandom_range(0, 3));
            ack = ($urandom_range(0, 2) == 0);
            v   = ($urandom_range(0, 1) == 1) && ((mq.size() < DEPTH) || (coalesce_slot(a) >= 0));
            if ($urandom_range(0, 99) == 0) do_reset(ack);
            else step(v, a, d, ack, la);
        end
        for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("final_idle", 64'(bus.mem_write_enable), 64'h0);
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/write_back_buffer.md
WRITE_BACK_BUFFER -- requirements
Module: write_back_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning data word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 32, meaning byte address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning number of buffer entries (power of two, at least 2).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port wb_valid, input, 1, cache presents a dirty eviction this cycle.
REQ-007 The block SHALL have port wb_address, input, ADDRESS_WIDTH, word-aligned eviction address.
REQ-008 The block SHALL have port wb_data, input, DATA_WIDTH, eviction data.
REQ-009 The block SHALL have port wb_full, output, 1, buffer cannot accept a new allocation.
REQ-010 The block SHALL have port mem_write_enable, output, 1, write request to main memory.
REQ-011 The block SHALL have port mem_address, output, ADDRESS_WIDTH, memory write address.
REQ-012 The block SHALL have port mem_write_data, output, DATA_WIDTH, memory write data.
REQ-013 The block SHALL have port mem_ack, input, 1, memory accepted the current write.
REQ-014 The block SHALL have port lookup_address, input, ADDRESS_WIDTH, cache miss address to check.
REQ-015 The block SHALL have port lookup_hit, output, 1, a buffered entry holds lookup_address.
REQ-016 The block SHALL have port lookup_data, output, DATA_WIDTH, data of the matching entry; 0 when no hit.

Function
REQ-017 The buffer SHALL be a circular FIFO with head/tail pointers and a count of width clog2(DEPTH)+1; pointers wrap from DEPTH-1 to 0.
REQ-018 wb_full SHALL equal (count == DEPTH) and SHALL be combinational from registered count only.
REQ-019 Coalescing: wb_valid with wb_address equal to a valid entry that is not in flight SHALL overwrite that entry's data, with no change to count, and SHALL be accepted even when wb_full=1.
REQ-020 Allocation: wb_valid with no coalesce match and wb_full=0 SHALL write the entry at tail, increment tail and increment count at the next posedge.
REQ-021 A push with wb_full=1 and no coalesce match SHALL be dropped; the upstream SHALL NOT assert wb_valid in that case, and the bench SHALL flag it.
REQ-022 The drain FSM SHALL have state IDLE, which moves to WRITE when count != 0.
REQ-023 The drain FSM SHALL have state WRITE, which stays in WRITE while mem_ack=0; on mem_ack=1 it pops the head and then goes to IDLE if the resulting count is 0, else stays in WRITE.
REQ-024 mem_write_enable SHALL be 1 exactly in WRITE; mem_address and mem_write_data SHALL present the head entry and SHALL be held stable until mem_ack.
REQ-025 The head entry SHALL be in flight while in WRITE, and pushes matching it SHALL allocate a new entry.
REQ-026 Latency: an entry allocated into an empty buffer at posedge N SHALL produce mem_write_enable=1 from posedge N+1.
REQ-027 When a pop and an allocation occur at the same posedge, count SHALL stay unchanged and both pointers SHALL advance; if count == DEPTH the allocation is refused per REQ-021.
REQ-028 Lookup SHALL be combinational over registered entries, including the in-flight entry.
REQ-029 Lookup SHALL NOT see a same-cycle push.
REQ-030 Lookup SHALL match at most one entry, which coalescing guarantees, except that an in-flight entry plus its newer copy may both match; then the newer entry SHALL win.
REQ-031 Address comparison SHALL ignore bits [1:0].

Reset
REQ-032 On rst=1 at posedge, count, head and tail SHALL become 0, all entry valid bits SHALL become 0 and the FSM SHALL become IDLE; entry data is not reset.
REQ-033 Outputs after reset SHALL be: wb_full=0, mem_write_enable=0, mem_address=0, mem_write_data=0, lookup_hit=0, lookup_data=0.
REQ-034 rst during WRITE SHALL abandon the in-flight write; a mem_ack in the reset cycle SHALL be ignored.

Structure
REQ-035 A shared package cache_pkg SHALL hold DATA_WIDTH, ADDRESS_WIDTH, the wb_entry_t struct (valid, address, data) and the drain_state_t enum (IDLE, WRITE).
REQ-036 The block SHALL contain one sub-module, wb_lookup_match, comparing one address against all entries and returning the youngest-match index and hit.

Verification
REQ-037 Scenario: after reset, push 0x0000_0040/0xDEAD_BEEF, with mem_ack asserted 2 cycles later -> mem_write_enable high from the next cycle; one write with these values; count returns to 0 and the FSM to IDLE.
REQ-038 Scenario: push 4 distinct addresses with mem_ack=0 -> wb_full=1.
REQ-039 Scenario: with the buffer of REQ-038 full, push 0x100 again with new data -> coalesced, wb_full stays 1, and the later write carries the new data.
REQ-040 Scenario: head 0x200 in flight, push 0x200/0x1111_1111 -> new entry allocated; lookup 0x200 returns 0x1111_1111; two memory writes in order.
REQ-041 Scenario: count=4 with mem_ack=1 and a new push in the same cycle -> push refused and flagged; count becomes 3.
REQ-042 Scenario: assert rst while in WRITE with mem_ack=1 -> next cycle mem_write_enable=0, lookup_hit=0 for a previously buffered address, and no pop is counted.
REQ-043 Scenario: 8 alloc/pop pairs -> pointers wrap and the write order equals the push order.
